// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: restoring division, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module mod_reduce_seq #(
    parameter int NUM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_WIDTH-1:0] num,
    input  logic [NUM_WIDTH-1:0] modulus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_WIDTH-1:0] quotient,
    output logic [NUM_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int CNT_WIDTH = $clog2(NUM_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [NUM_WIDTH-1:0]   dvd_r;
    logic [NUM_WIDTH-1:0]   mod_r;
    logic [NUM_WIDTH-1:0]   prem_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [NUM_WIDTH-1:0]   quotient_r;
    logic [NUM_WIDTH-1:0]   remainder_r;
    logic                   dbz_r;
    logic                   in_ready_r;
    logic                   out_valid_r;

    logic [NUM_WIDTH:0]     shift_s;
    logic [NUM_WIDTH-1:0]   diff_s;
    logic [NUM_WIDTH-1:0]   prem_nx_s;
    logic                   ge_s;
    logic                   last_s;
    logic                   accept_s;
    logic                   in_ready_nx_s;
    logic                   out_valid_nx_s;

    // One restoring-division step; the shifted value carries an extra MSB so
    // moduli above half range never overflow. The stored remainder stays < modulus.
    always_comb begin
        shift_s   = {1'b0, prem_r, dvd_r[NUM_WIDTH-1]};
        shift_s   = {prem_r, dvd_r[NUM_WIDTH-1]};
        ge_s      = (shift_s >= {1'b0, mod_r});
        diff_s    = NUM_WIDTH'(shift_s - {1'b0, mod_r});
        prem_nx_s = shift_s[NUM_WIDTH-1:0];
        if (ge_s) begin
            prem_nx_s = diff_s;
        end else begin
            prem_nx_s = shift_s[NUM_WIDTH-1:0];
        end
        last_s   = (cnt_r == CNT_WIDTH'(NUM_WIDTH - 1));
        accept_s = (state_r == ST_IDLE) && in_valid;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; zero modulus and num < modulus skip the iteration phase.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((modulus == {NUM_WIDTH{1'b0}}) || (num < modulus)) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_CALC;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so they can be registered.
    always_comb begin
        in_ready_nx_s  = (state_nx_s == ST_IDLE);
        out_valid_nx_s = (state_nx_s == ST_DONE);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
        end
    end

    // Datapath: operand capture, iteration, and result registers. The dividend
    // register doubles as the quotient shift register during iteration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_r       <= {NUM_WIDTH{1'b0}};
            mod_r       <= {NUM_WIDTH{1'b0}};
            prem_r      <= {NUM_WIDTH{1'b0}};
            cnt_r       <= {CNT_WIDTH{1'b0}};
            quotient_r  <= {NUM_WIDTH{1'b0}};
            remainder_r <= {NUM_WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        dvd_r  <= num;
                        mod_r  <= modulus;
                        prem_r <= {NUM_WIDTH{1'b0}};
                        cnt_r  <= {CNT_WIDTH{1'b0}};
                        if (modulus == {NUM_WIDTH{1'b0}}) begin
                            quotient_r  <= {NUM_WIDTH{1'b1}};
                            remainder_r <= num;
                            dbz_r       <= 1'b1;
                        end else if (num < modulus) begin
                            quotient_r  <= {NUM_WIDTH{1'b0}};
                            remainder_r <= num;
                            dbz_r       <= 1'b0;
                        end else begin
                            dbz_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_CALC: begin
                    dvd_r  <= {dvd_r[NUM_WIDTH-2:0], ge_s};
                    prem_r <= prem_nx_s;
                    cnt_r  <= cnt_r + CNT_WIDTH'(1);
                    if (last_s) begin
                        quotient_r  <= {dvd_r[NUM_WIDTH-2:0], ge_s};
                        remainder_r <= prem_nx_s;
                    end else begin
                        quotient_r  <= quotient_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Self-checking bench for mod_reduce_seq (NUM_WIDTH=8): directed and random
// operations compared against plain integer division.
module tb_mod_reduce_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] num;
    logic [7:0] modulus;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total;
    int bad;

    mod_reduce_seq #(.NUM_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num         (num),
        .modulus     (modulus),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and wait for its result without consuming it.
    // busy_ok reports whether in_ready stayed low while the result was pending.
    task automatic run_op(input logic [7:0] n, input logic [7:0] m,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic z, output int lat, output logic busy_ok);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        num = n;
        modulus = m;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        num = 8'($urandom);
        modulus = 8'($urandom);
        in_valid = 1'b0;
        busy_ok = 1'b1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        in_valid = 1'b0;
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        num = 8'd0;
        modulus = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        total++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: q=%0d r=%0d dbz=%b required 0/0/0", quotient, remainder, div_by_zero);
        end
    endtask

    // Table-driven ops from the plan plus random ones, each against integer arithmetic.
    task automatic test_ops(input int n_random);
        logic [7:0] tn [7] = '{8'd200, 8'd5, 8'd255, 8'd255, 8'd254, 8'd100, 8'd9};
        logic [7:0] tm [7] = '{8'd7,   8'd9, 8'd255, 8'd128, 8'd200, 8'd0,   8'd3};
        logic [7:0] n, m, q, r, eq, er;
        logic z, ez, busy_ok;
        int lat, elat;
        for (int i = 0; i < 7 + n_random; i++) begin
            if (i < 7) begin
                n = tn[i];
                m = tm[i];
            end else begin
                n = 8'($urandom);
                case ($urandom_range(0, 3))
                    0: m = 8'd0;
                    1: m = 8'($urandom_range(1, 15));
                    default: m = 8'($urandom_range(1, 255));
                endcase
            end
            if (m == 8'd0) begin
                eq = 8'hFF; er = n; ez = 1'b1; elat = 1;
            end else begin
                eq = n / m; er = n % m; ez = 1'b0;
                elat = (n < m) ? 1 : 9;
            end
            run_op(n, m, q, r, z, lat, busy_ok);
            total++;
            if (q !== eq || r !== er || z !== ez) begin
                bad++;
                $display("FAIL result %0d/%0d: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                         n, m, q, r, z, eq, er, ez);
            end
            total++;
            if (lat !== elat) begin
                bad++;
                $display("FAIL latency %0d/%0d: got %0d required %0d", n, m, lat, elat);
            end
            total++;
            if (busy_ok !== 1'b1) begin
                bad++;
                $display("FAIL busy_ready %0d/%0d: in_ready rose before result consumed", n, m);
            end
            consume();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== eq || remainder !== er) begin
                bad++;
                $display("FAIL after_consume %0d/%0d: out_valid=%b in_ready=%b q=%0d r=%0d required 0/1/%0d/%0d",
                         n, m, out_valid, in_ready, quotient, remainder, eq, er);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q, r;
        logic z, busy_ok, held;
        int lat;
        run_op(8'd50, 8'd3, q, r, z, lat, busy_ok);
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            num = 8'($urandom);
            modulus = 8'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd16 || remainder !== 8'd2)
                held = 1'b0;
        end
        in_valid = 1'b0;
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_hold: outputs or handshake changed while out_ready low (q=%0d r=%0d)",
                     quotient, remainder);
        end
        consume();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q, r;
        logic z, busy_ok;
        int lat;
        num = 8'd200;
        modulus = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b q=%0d r=%0d required 1/0/0/0",
                     in_ready, out_valid, quotient, remainder);
        end
        run_op(8'd17, 8'd5, q, r, z, lat, busy_ok);
        total++;
        if (q !== 8'd3 || r !== 8'd2 || z !== 1'b0 || lat !== 9) begin
            bad++;
            $display("FAIL after_reset_op: q=%0d r=%0d dbz=%b lat=%0d required 3/2/0/9", q, r, z, lat);
        end
        consume();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_ops(30);
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
